// File: rtl/conv_ram_reader.sv
// Walks a height x width window of the conv RAM in row-major order and streams
// the read data out through a small FIFO with valid/ready flow control.
module conv_ram_reader #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 8,
   parameter int FIFO_D = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [7:0]        width,
   input  logic [7:0]        height,
   input  logic [ADDR_W-1:0] pitch,
   output logic [ADDR_W-1:0] rdaddress,
   input  logic [DATA_W-1:0] q,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_eol,
   output logic              out_last,
   output logic              busy,
   output logic              done
);
   localparam int PTR_W = $clog2(FIFO_D);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FLUSH} state_t;

   state_t            r_state;
   state_t            w_next;

   logic [ADDR_W-1:0] r_rdaddress;
   logic [ADDR_W-1:0] r_row_start;
   logic [ADDR_W-1:0] r_pitch;
   logic [7:0]        r_width;
   logic [7:0]        r_height;
   logic [7:0]        r_col;
   logic [7:0]        r_row;
   logic              r_pend;
   logic              r_ret;
   logic              r_ret_eol;
   logic              r_ret_last;
   logic              r_done;

   logic [DATA_W-1:0] r_mem_data [FIFO_D];
   logic              r_mem_eol  [FIFO_D];
   logic              r_mem_last [FIFO_D];
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_count;

   logic              w_accept;
   logic              w_zero;
   logic              w_cur_eol;
   logic              w_cur_last;
   logic              w_issue;
   logic              w_valid;
   logic              w_pop;
   logic              w_head_last;
   logic [CNT_W-1:0]  w_occ;
   logic [ADDR_W-1:0] w_next_row;

   assign w_accept    = (r_state == S_IDLE) && start;
   assign w_zero      = (width == 8'd0) || (height == 8'd0);
   // Coordinates describe the element whose address is currently on rdaddress.
   assign w_cur_eol   = (r_col == r_width - 8'd1);
   assign w_cur_last  = w_cur_eol && (r_row == r_height - 8'd1);
   // Every read not yet written into the FIFO counts against its capacity.
   assign w_occ       = r_count + CNT_W'(r_pend) + CNT_W'(r_ret);
   assign w_issue     = (r_state == S_RUN) && !w_cur_last && (w_occ < CNT_W'(FIFO_D));
   assign w_valid     = (r_count != '0);
   assign w_pop       = w_valid && out_ready;
   assign w_head_last = r_mem_last[r_rptr];
   assign w_next_row  = r_row_start + r_pitch;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = w_zero ? S_FLUSH : S_RUN;
         S_RUN:   if (w_cur_last) w_next = S_DRAIN;
         S_DRAIN: if (w_pop && w_head_last) w_next = S_IDLE;
         S_FLUSH: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (r_state != S_IDLE);
      done      = (r_state == S_FLUSH) || r_done;
      out_valid = w_valid;
      out_data  = w_valid ? r_mem_data[r_rptr] : '0;
      out_eol   = w_valid && r_mem_eol[r_rptr];
      out_last  = w_valid && r_mem_last[r_rptr];
      rdaddress = r_rdaddress;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rdaddress <= '0;
         r_col       <= '0;
         r_row       <= '0;
         r_pend      <= 1'b0;
         r_ret       <= 1'b0;
         r_ret_eol   <= 1'b0;
         r_ret_last  <= 1'b0;
         r_done      <= 1'b0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
      end else begin
         r_pend     <= w_accept ? !w_zero : w_issue;
         r_ret      <= r_pend;
         r_ret_eol  <= w_cur_eol;
         r_ret_last <= w_cur_last;
         r_done     <= w_pop && w_head_last;

         if (w_accept) begin
            r_rdaddress <= base_addr;
            r_col       <= '0;
            r_row       <= '0;
         end else if (w_issue) begin
            if (w_cur_eol) begin
               r_col       <= '0;
               r_row       <= r_row + 8'd1;
               r_rdaddress <= w_next_row;
            end else begin
               r_col       <= r_col + 8'd1;
               r_rdaddress <= r_rdaddress + ADDR_W'(1);
            end
         end

         if (r_ret) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
         case ({r_ret, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Command operands and FIFO storage carry no reset; the outputs are gated by valid.
   always_ff @(posedge clock) begin
      if (w_accept) begin
         r_width     <= width;
         r_height    <= height;
         r_pitch     <= pitch;
         r_row_start <= base_addr;
      end else if (w_issue && w_cur_eol) begin
         r_row_start <= w_next_row;
      end

      if (r_ret) begin
         r_mem_data[r_wptr] <= q;
         r_mem_eol[r_wptr]  <= r_ret_eol;
         r_mem_last[r_wptr] <= r_ret_last;
      end
   end

endmodule

// File: tb/tb_conv_ram_reader.sv
// Scoreboard bench for conv_ram_reader: a RAM model plus a row-major reference
// queue, checked by an independent output monitor.
module tb_conv_ram_reader;
   localparam int AW = 15;
   localparam int DW = 16;
   localparam int FD = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [7:0]    width;
   logic [7:0]    height;
   logic [AW-1:0] pitch;
   logic [AW-1:0] rdaddress;
   logic [DW-1:0] q;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_eol;
   logic          out_last;
   logic          busy;
   logic          done;

   typedef struct {
      logic [DW-1:0] d;
      logic          eol;
      logic          last;
   } exp_t;

   exp_t          sb[$];
   int            n_tests = 0;
   int            n_fail = 0;
   int            ready_pct = 100;
   logic [DW-1:0] salt = '0;
   logic          done_arm = 1'b0;
   logic          flush_arm = 1'b0;

   always #5 clock = ~clock;

   conv_ram_reader #(.ADDR_W(AW), .DATA_W(DW), .FIFO_D(FD)) dut (
      .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
      .width(width), .height(height), .pitch(pitch), .rdaddress(rdaddress),
      .q(q), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_eol(out_eol), .out_last(out_last), .busy(busy), .done(done)
   );

   // RAM contents are an injective function of the address, salted per command.
   function automatic logic [DW-1:0] ramfn(input logic [AW-1:0] a);
      return {1'b0, a} ^ salt;
   endfunction

   always @(posedge clock) q <= ramfn(rdaddress);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic push_model(input logic [AW-1:0] b, input logic [7:0] w,
                             input logic [7:0] h, input logic [AW-1:0] p);
      for (int r = 0; r < int'(h); r++) begin
         for (int c = 0; c < int'(w); c++) begin
            exp_t e;
            int unsigned s;
            s      = int'(b) + r * int'(p) + c;
            e.d    = ramfn(AW'(s));
            e.eol  = (c == int'(w) - 1);
            e.last = (r == int'(h) - 1) && (c == int'(w) - 1);
            sb.push_back(e);
         end
      end
   endtask

   task automatic issue(input logic [AW-1:0] b, input logic [7:0] w,
                        input logic [7:0] h, input logic [AW-1:0] p);
      @(negedge clock);
      salt      = DW'($urandom);
      base_addr = b;
      width     = w;
      height    = h;
      pitch     = p;
      start     = 1'b1;
      push_model(b, w, h, p);
      @(posedge clock);
      #1;
      start = 1'b0;
      if (w == 8'd0 || h == 8'd0) flush_arm = 1'b1;
   endtask

   // Called one tick into cycle 1; requires out_ready held high.
   task automatic chk_addrs(input logic [AW-1:0] b, input logic [7:0] w,
                            input logic [7:0] h, input logic [AW-1:0] p);
      int k;
      k = 0;
      for (int r = 0; r < int'(h); r++) begin
         for (int c = 0; c < int'(w); c++) begin
            int unsigned s;
            s = int'(b) + r * int'(p) + c;
            @(negedge clock);
            chk("rdaddress_seq", 32'(rdaddress), 32'(AW'(s)));
            if (k == 1) chk("valid_cycle2", 32'(out_valid), 32'd0);
            if (k == 2) chk("valid_cycle3", 32'(out_valid), 32'd1);
            k++;
         end
      end
   endtask

   task automatic wait_idle(input string nm);
      int k;
      k = 0;
      while ((sb.size() != 0 || busy) && k < 3000) begin
         @(posedge clock);
         #2;
         k++;
      end
      n_tests++;
      if (k >= 3000) begin
         n_fail++;
         $display("FAIL %s_timeout: got %0d words left, expected 0 within 3000 cycles", nm, sb.size());
      end
      repeat (2) begin
         @(posedge clock);
         #2;
      end
   endtask

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         out_ready = ($urandom_range(0, 99) < ready_pct);
      end
   end

   initial begin
      exp_t          e;
      logic [DW-1:0] pd;
      logic          pe, pl, ps, exp_done;
      ps = 1'b0;
      pd = '0;
      pe = 1'b0;
      pl = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            sb.delete();
            done_arm  = 1'b0;
            flush_arm = 1'b0;
            ps        = 1'b0;
         end else begin
            exp_done  = done_arm | flush_arm;
            done_arm  = 1'b0;
            flush_arm = 1'b0;
            if (done || exp_done) chk("done_pulse", 32'(done), 32'(exp_done));
            if (ps) begin
               chk("stall_valid", 32'(out_valid), 32'd1);
               chk("stall_data", 32'(out_data), 32'(pd));
               chk("stall_flags", {30'd0, out_eol, out_last}, {30'd0, pe, pl});
            end
            if (out_valid) begin
               if (sb.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_word: got data %0h, expected no word", out_data);
               end else begin
                  e = sb[0];
                  chk("out_data", 32'(out_data), 32'(e.d));
                  chk("out_eol", 32'(out_eol), 32'(e.eol));
                  chk("out_last", 32'(out_last), 32'(e.last));
                  if (out_ready) begin
                     void'(sb.pop_front());
                     if (e.last) done_arm = 1'b1;
                  end
               end
            end
            ps = out_valid && !out_ready;
            pd = out_data;
            pe = out_eol;
            pl = out_last;
         end
      end
   end

   initial begin
      logic [AW-1:0] b, p;
      logic [7:0]    w, h;
      reset     = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      width     = '0;
      height    = '0;
      pitch     = '0;
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rdaddress", 32'(rdaddress), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_flags", {30'd0, out_eol, out_last}, 32'd0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      ready_pct = 100;
      issue(15'd100, 8'd3, 8'd2, 15'd64);
      chk_addrs(15'd100, 8'd3, 8'd2, 15'd64);
      wait_idle("basic");

      issue(15'd32766, 8'd4, 8'd1, 15'd9);
      chk_addrs(15'd32766, 8'd4, 8'd1, 15'd9);
      wait_idle("wrap");

      issue(15'd200, 8'd1, 8'd3, 15'd5);
      wait_idle("width1");

      issue(15'd50, 8'd0, 8'd5, 15'd10);
      @(negedge clock);
      chk("flush_busy_c1", 32'(busy), 32'd1);
      chk("flush_valid_c1", 32'(out_valid), 32'd0);
      @(negedge clock);
      chk("flush_busy_c2", 32'(busy), 32'd0);
      chk("flush_valid_c2", 32'(out_valid), 32'd0);
      repeat (2) @(posedge clock);

      ready_pct = 30;
      issue(AW'($urandom), 8'd8, 8'd8, AW'($urandom_range(8, 300)));
      wait_idle("grid8x8");

      ready_pct = 60;
      issue(15'd1000, 8'd5, 8'd3, 15'd40);
      @(negedge clock);
      @(negedge clock);
      base_addr = 15'd5;
      width     = 8'd2;
      height    = 8'd2;
      pitch     = 15'd7;
      start     = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      wait_idle("start_in_run");

      ready_pct = 100;
      issue(15'd3000, 8'd4, 8'd4, 15'd20);
      repeat (6) @(posedge clock);
      #1;
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      chk("pre_rst_5th", 32'(out_data), 32'(ramfn(15'd3020)));
      reset = 1'b1;
      #1;
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_rdaddress", 32'(rdaddress), 32'd0);
      chk("abort_data", 32'(out_data), 32'd0);
      chk("abort_flags", {30'd0, out_eol, out_last}, 32'd0);
      repeat (2) @(posedge clock);
      #1;
      reset     = 1'b0;
      salt      = DW'($urandom);
      base_addr = 15'd777;
      width     = 8'd3;
      height    = 8'd3;
      pitch     = 15'd100;
      start     = 1'b1;
      push_model(15'd777, 8'd3, 8'd3, 15'd100);
      @(posedge clock);
      #1;
      start = 1'b0;
      chk("post_rst_accept", 32'(busy), 32'd1);
      wait_idle("post_reset");

      for (int i = 0; i < 6; i++) begin
         b = AW'($urandom);
         if (i % 2 == 1) b = 15'h7FFC;
         w = 8'($urandom_range(1, 6));
         h = 8'($urandom_range(1, 4));
         p = AW'($urandom_range(0, 200));
         ready_pct = $urandom_range(20, 100);
         issue(b, w, h, p);
         wait_idle("random");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_ram_reader.md
CONV_RAM_READER -- requirements
Module: conv_ram_reader

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_W, 15, RAM address width.
- DATA_W, 8, RAM data width.
- FIFO_D, 4, output buffer depth in entries (power of 2, at least 4).
REQ-002 Ports (name, direction, width, meaning):
- clock, in, 1: single clock; all logic on its rising edge.
- reset, in, 1: asynchronous, active-high reset.
- start, in, 1: one-cycle command strobe.
- base_addr, in, ADDR_W: address of the first element.
- width, in, 8: columns per row.
- height, in, 8: number of rows.
- pitch, in, ADDR_W: address increment between the starts of consecutive rows.
- rdaddress, out, ADDR_W: registered read address to the conv RAM.
- q, in, DATA_W: RAM read data, valid one cycle after its rdaddress was presented.
- out_data, out, DATA_W: stream data.
- out_valid, out, 1: stream data valid.
- out_ready, in, 1: sink accepts the stream word.
- out_eol, out, 1: current word is the last in its row.
- out_last, out, 1: current word is the last of the command.
- busy, out, 1: a command is in progress.
- done, out, 1: one-cycle completion pulse.

Function
REQ-003 Command capture: start is sampled only in IDLE. base_addr, width, height and pitch are latched on that edge. start while busy=1 shall be ignored.
REQ-004 States are IDLE, RUN, DRAIN and FLUSH:
- IDLE->RUN on an accepted start with width≠0 and height≠0.
- IDLE->FLUSH on an accepted start with width=0 or height=0.
- RUN->DRAIN after the final read address is issued.
- DRAIN->IDLE when the word with out_last=1 is accepted.
- FLUSH->IDLE unconditionally after one cycle.
REQ-005 busy=1 in RUN, DRAIN and FLUSH; busy=0 in IDLE.
REQ-006 done shall pulse for exactly one cycle:
- in the cycle after the out_last word handshake (out_valid and out_ready both 1), or
- in the FLUSH cycle, with no stream words emitted.
REQ-007 Address sequence, row-major:
- element (r,c) reads base_addr + r*pitch + c, for r<height, c<width.
- All address sums are computed modulo 2^ADDR_W; wrap from 32767 to 0 is legal.
- Implementation uses a row-start register plus a column offset; no multiplier.
REQ-008 Issue rule: at most one read per cycle. A read is issued in a cycle only when (FIFO occupancy + reads in flight) < FIFO_D.
REQ-009 Read latency accounting: a read issued (rdaddress presented) in cycle t yields q in cycle t+1. The block writes that q into the FIFO at the end of cycle t+1, tagged with its eol and last flags.
REQ-010 Output handshake:
- out_data, out_eol and out_last come from the FIFO head.
- out_valid=1 whenever the FIFO is non-empty.
- Once out_valid=1, out_data, out_eol and out_last shall hold stable until the handshake.
- Simultaneous FIFO push and pop in the same cycle are legal and leave occupancy unchanged.
REQ-011 Latency and throughput:
- start sampled at the end of cycle 0 gives rdaddress=base_addr in cycle 1 and first out_valid=1 in cycle 3.
- With out_ready held at 1, one word per cycle is sustained with no bubbles.
REQ-012 Flags:
- out_eol=1 on column width-1 of every row.
- out_last=1 only on element (height-1, width-1).
- The width=1 case sets out_eol on every word.
REQ-013 When idle, rdaddress holds its last value; it has no functional meaning.

Reset
REQ-014 Reset asserted shall immediately force:
- state=IDLE, busy=0, done=0, out_valid=0, out_eol=0, out_last=0;
- FIFO empty, in-flight count=0, rdaddress=0, out_data=0.
REQ-015 Reset mid-command shall abort it. No done is generated, and q returning after reset release is discarded.
REQ-016 After release, the first start shall be accepted on the first rising edge.

Verification
REQ-017 Bench shall cover:
- base=100, width=3, height=2, pitch=64, out_ready=1 -> rdaddress 100,101,102,164,165,166; eol on words 3 and 6; last on word 6; done one cycle after the word-6 handshake.
- base=32766, width=4, height=1 -> addresses 32766,32767,0,1.
- width=0, height=5 -> no out_valid, done pulses exactly one cycle later, busy high for one cycle.
- width=8, height=8, random out_ready at 30% -> 64 words in order, no loss or duplicates, data stable while stalled, FIFO never overflows.
- start re-asserted during RUN -> ignored; output matches the first command only.
- reset asserted on the 5th word of a 16-word command -> outputs cleared immediately, no done; a new command after release completes correctly.
